sha256_msg_sched: RTL and testbench
===================================

Name: sha256_msg_sched

Overview:
- Downstream neighbour of the header padding stage.
- Accepts the 1024-bit padded block-header message: two SHA-256 blocks, 640-bit header plus padding and length.
- Emits the SHA-256 message-schedule words W[0..63] for block 0, then for block 1, one word per handshake, to the compression core.
- Holds a 16-word sliding window and computes each expanded word on the fly; there is no 64-entry storage.

Parameters:
- NUM_BLOCKS, 2, number of 512-bit blocks per message; MSG_W = 512*NUM_BLOCKS.
- ROUNDS, 64, schedule words emitted per block; must be >= 16.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- msg_in  in  MSG_W  padded message; bit MSG_W-1 is the first message bit.
- msg_valid  in  1  msg_in is valid.
- msg_ready  out  1  block can accept a message.
- w_out  out  32  current schedule word.
- w_valid  out  1  w_out is valid.
- w_ready  in  1  consumer accepts w_out.
- w_idx  out  6  round index t of w_out, 0..ROUNDS-1.
- blk_idx  out  clog2(NUM_BLOCKS) (min 1)  block index of w_out.
- blk_first  out  1  w_valid && w_idx==0; tells the core to load its chaining state.
- blk_last  out  1  w_valid && w_idx==ROUNDS-1.
- msg_last  out  1  blk_last && blk_idx==NUM_BLOCKS-1.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, msg_ready=1, w_valid=0, w_idx=0, blk_idx=0, w_out=0, message register cleared. Reset mid-message abandons the message; no further words are emitted.
- State IDLE:
  - msg_ready=1.
  - On msg_valid && msg_ready: capture msg_in into the message register.
  - Load window[0..15] with block 0 words, big-endian: window[i] = msg_in[MSG_W-1-32*i -: 32].
  - Go to RUN.
  - w_valid rises on the next cycle with W[0]. Latency is 1 cycle from accept to first word.
- State RUN:
  - msg_ready=0 and msg_valid is ignored.
  - w_out = window[0], registered.
  - w_valid and w_out are held stable until w_ready. Only w_valid && w_ready advances.
- Advance when w_idx < ROUNDS-1:
  - Shift window down by one word.
  - window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32. Carries are discarded.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - w_idx++.
- Advance when w_idx == ROUNDS-1 and blk_idx < NUM_BLOCKS-1:
  - blk_idx++, w_idx=0.
  - Window reloaded with the next block's 16 words from the message register.
  - w_valid stays 1; there is no bubble.
- Advance when w_idx == ROUNDS-1 and blk_idx == NUM_BLOCKS-1:
  - Go to IDLE. w_valid=0, blk_idx=0, w_idx=0.
  - msg_ready=1 on the following cycle.
  - A new message can be accepted no earlier than 1 cycle after the last word handshake.
- w_ready held low indefinitely: all outputs frozen, no internal progress.
- w_ready=1 continuously: one word per cycle. Throughput is NUM_BLOCKS*ROUNDS cycles per message, plus 1 idle/accept cycle.
- msg_in may change after acceptance; the block uses only the captured copy.

Optional Feature:
- Macro: SCHED_FLUSH_EN.
- With the macro defined:
  - Adds input port flush (1 bit).
  - flush=1 in any state forces IDLE next cycle, same values as reset, but leaves the message register unchanged.
  - flush has priority over a same-cycle word handshake or message accept; neither takes effect.
- Without the macro: the port does not exist, and only rst aborts a message.

Test Plan:
- Single "abc" block, NUM_BLOCKS=1, msg_in = 0x61626380 followed by 14 zero words then 0x00000018, w_ready=1 -> W0=0x61626380, W1..W14=0, W15=0x00000018, W16=0x61626380, W17=0x000F0000; 64 words on consecutive cycles; blk_last and msg_last at t=63; msg_ready=1 one cycle later.
- 1024-bit padded header, NUM_BLOCKS=2 -> block 1 words 4..15 = 0x80000000, then 10×0, then 0x00000280; blk_idx switches 0->1 with no gap; w_idx wraps 63->0; blk_first asserted twice; 128 words total.
- Back-pressure: toggle w_ready 0/1 pseudo-randomly -> word sequence identical to the w_ready=1 run; w_out stable whenever w_valid && !w_ready.
- msg_valid held high during RUN with different data -> ignored, msg_ready=0; the second message is accepted only after the IDLE return; its words are correct.
- rst asserted at block 1, w_idx=20 -> next cycle w_valid=0, msg_ready=1, indices 0; the next message schedules correctly from W0.
- SCHED_FLUSH_EN defined: flush coincident with a word handshake at t=10 -> no advance, IDLE next cycle; without the macro, the design compiles with no flush port.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message-schedule generator.
// Takes a padded NUM_BLOCKS x 512-bit message. For each block it emits
// W[0..ROUNDS-1], one word per w_valid/w_ready handshake. The words are
// expanded on the fly from a 16-word sliding window.
// Optional feature macro: SCHED_FLUSH_EN adds a 'flush' input. Flush
// aborts the current message like rst, but keeps the message register.
module sha256_msg_sched #(
    parameter  int unsigned NUM_BLOCKS = 2,
    parameter  int unsigned ROUNDS     = 64,
    localparam int unsigned MSG_W      = 512 * NUM_BLOCKS,
    localparam int unsigned BW         = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SCHED_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [MSG_W-1:0] msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [31:0]      w_out,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [5:0]       w_idx,
    output logic [BW-1:0]    blk_idx,
    output logic             blk_first,
    output logic             blk_last,
    output logic             msg_last
);

    localparam logic [5:0]    LAST_T = 6'(ROUNDS - 1);
    localparam logic [BW-1:0] LAST_B = BW'(NUM_BLOCKS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state, state_n;
    logic [MSG_W-1:0]  msg_reg, msg_n;
    logic [31:0]       window   [16];
    logic [31:0]       window_n [16];
    logic [5:0]        w_idx_n;
    logic [BW-1:0]     blk_idx_n;
    logic              abort;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef SCHED_FLUSH_EN
    assign abort = flush;
`else
    assign abort = 1'b0;
`endif

    // Outputs come straight from the state, index and window registers
    assign msg_ready = (state == IDLE);
    assign w_valid   = (state == RUN);
    assign w_out     = window[0];
    assign blk_first = w_valid && (w_idx == 6'd0);
    assign blk_last  = w_valid && (w_idx == LAST_T);
    assign msg_last  = blk_last && (blk_idx == LAST_B);

    // Next-state, window-update and message-capture logic
    always_comb begin
        state_n   = state;
        msg_n     = msg_reg;
        w_idx_n   = w_idx;
        blk_idx_n = blk_idx;
        for (int unsigned i = 0; i < 16; i++) begin
            window_n[i] = window[i];
        end

        case (state)
            IDLE: begin
                if (msg_valid) begin
                    msg_n     = msg_in;
                    w_idx_n   = '0;
                    blk_idx_n = '0;
                    state_n   = RUN;
                    for (int unsigned i = 0; i < 16; i++) begin
                        window_n[i] = msg_in[MSG_W - 1 - 32 * i -: 32];
                    end
                end
            end
            RUN: begin
                if (w_ready) begin
                    if (w_idx != LAST_T) begin
                        for (int unsigned i = 0; i < 15; i++) begin
                            window_n[i] = window[i + 1];
                        end
                        window_n[15] = sig1(window[14]) + window[9]
                                     + sig0(window[1]) + window[0];
                        w_idx_n = w_idx + 6'd1;
                    end else if (blk_idx != LAST_B) begin
                        blk_idx_n = blk_idx + 1'b1;
                        w_idx_n   = '0;
                        // The loop over k keeps every part select constant.
                        // The block index only picks which load is used.
                        for (int unsigned k = 0; k < NUM_BLOCKS; k++) begin
                            if (BW'(k) == blk_idx + 1'b1) begin
                                for (int unsigned i = 0; i < 16; i++) begin
                                    window_n[i] = msg_reg[MSG_W - 1 - 512 * k - 32 * i -: 32];
                                end
                            end
                        end
                    end else begin
                        state_n   = IDLE;
                        w_idx_n   = '0;
                        blk_idx_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort wins over a same-cycle handshake or accept; message kept
        if (abort) begin
            state_n   = IDLE;
            msg_n     = msg_reg;
            w_idx_n   = '0;
            blk_idx_n = '0;
            for (int unsigned i = 0; i < 16; i++) begin
                window_n[i] = '0;
            end
        end
    end

    // State, window, index and message registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            msg_reg <= '0;
            w_idx   <= '0;
            blk_idx <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                window[i] <= '0;
            end
        end else begin
            state   <= state_n;
            msg_reg <= msg_n;
            w_idx   <= w_idx_n;
            blk_idx <= blk_idx_n;
            for (int unsigned i = 0; i < 16; i++) begin
                window[i] <= window_n[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched (NUM_BLOCKS=2, ROUNDS=64).
// Accepted messages are expanded by a full-array reference model into an
// expected-word queue. A monitor pops and compares each handshaken word.
module tb_sha256_msg_sched;

    localparam int unsigned NB = 2;
    localparam int unsigned R  = 64;
    localparam int unsigned MW = 512 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic [MW-1:0] msg_in;
    logic          msg_valid;
    logic          msg_ready;
    logic [31:0]   w_out;
    logic          w_valid;
    logic          w_ready;
    logic [5:0]    w_idx;
    logic [0:0]    blk_idx;
    logic          blk_first;
    logic          blk_last;
    logic          msg_last;
    logic          abort;
`ifdef SCHED_FLUSH_EN
    logic          flush;
    assign abort = rst | flush;
`else
    assign abort = rst;
`endif

    sha256_msg_sched #(.NUM_BLOCKS(NB), .ROUNDS(R)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SCHED_FLUSH_EN
        .flush     (flush),
`endif
        .msg_in    (msg_in),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .w_out     (w_out),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_idx     (w_idx),
        .blk_idx   (blk_idx),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .msg_last  (msg_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        int unsigned t;
        int unsigned b;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          accepts = 0;
    int          popped = 0;
    int          firsts = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_pop_cyc = 0;
    bit          bp_mode = 1'b0;
    bit          bp_const = 1'b1;
    bit          kv_en [128];
    logic [31:0] kv_w  [128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference model: textbook full 64-entry schedule per block
    task automatic push_msg(input logic [MW-1:0] m);
        logic [31:0] W [64];
        logic [MW-1:0] tmp;
        exp_t e;
        for (int b = 0; b < int'(NB); b++) begin
            for (int t = 0; t < 16; t++) begin
                tmp  = m << (512 * b + 32 * t);
                W[t] = tmp[MW-1 -: 32];
            end
            for (int t = 16; t < 64; t++) begin
                W[t] = (rotr(W[t-2], 17) ^ rotr(W[t-2], 19) ^ (W[t-2] >> 10))
                     + W[t-7]
                     + (rotr(W[t-15], 7) ^ rotr(W[t-15], 18) ^ (W[t-15] >> 3))
                     + W[t-16];
            end
            for (int t = 0; t < int'(R); t++) begin
                e.w = W[t]; e.t = t; e.b = b;
                sb.push_back(e);
            end
        end
    endtask

    function automatic logic [MW-1:0] pack(input logic [31:0] words [32]);
        logic [MW-1:0] m = '0;
        for (int j = 0; j < 32; j++) m = {m[MW-33:0], words[j]};
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_msg();
        logic [31:0] words [32];
        for (int j = 0; j < 32; j++) words[j] = $urandom();
        return pack(words);
    endfunction

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // w_ready driver: constant or pseudo-random per cycle
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            w_ready = bp_mode ? 1'($urandom_range(0, 1)) : bp_const;
        end
    end

    // Accept monitor: push expected words for each accepted message
    initial forever begin
        @(negedge clk);
        if (!abort && msg_valid && msg_ready) begin
            push_msg(msg_in);
            accepts++;
            acc_cyc = cyc;
        end
    end

    // Word monitor: compare handshaken words, check hold stability
    initial begin
        exp_t        e;
        bit          hold_v = 1'b0;
        logic [31:0] hold_w = '0;
        int unsigned k;
        forever begin
            @(negedge clk);
            if (abort) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", 32'(w_valid), 32'd1);
                    chk("hold_w_out", w_out, hold_w);
                    hold_v = 1'b0;
                end
                if (w_valid) begin
                    chk("ready_in_run", 32'(msg_ready), 32'd0);
                    if (w_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_word", w_out, 32'hxxxx_xxxx);
                        end else begin
                            e = sb.pop_front();
                            chk("w_out",     w_out, e.w);
                            chk("w_idx",     32'(w_idx), 32'(e.t));
                            chk("blk_idx",   32'(blk_idx), 32'(e.b));
                            chk("blk_first", 32'(blk_first), 32'(e.t == 0));
                            chk("blk_last",  32'(blk_last), 32'(e.t == R - 1));
                            chk("msg_last",  32'(msg_last), 32'(e.t == R - 1 && e.b == NB - 1));
                            k = e.b * 64 + e.t;
                            if (kv_en[k]) chk("known_word", w_out, kv_w[k]);
                            if (blk_first) firsts++;
                            popped++;
                            last_pop_cyc = cyc;
                        end
                    end else begin
                        hold_v = 1'b1;
                        hold_w = w_out;
                    end
                end
            end
        end
    end

    task automatic send_msg(input logic [MW-1:0] m);
        int a0 = accepts;
        int n = 0;
        msg_in    = m;
        msg_valid = 1'b1;
        while (accepts == a0 && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (accepts == a0) chk("accept_timeout", 32'd1, 32'd0);
        msg_valid = 1'b0;
        msg_in    = rand_msg();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(sb.size() == 0 && !w_valid) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_popped(input int target);
        int n = 0;
        while (popped < target && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) chk("pop_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_w_valid"},   32'(w_valid), 32'd0);
        chk({tag, "_msg_ready"}, 32'(msg_ready), 32'd1);
        chk({tag, "_w_idx"},     32'(w_idx), 32'd0);
        chk({tag, "_blk_idx"},   32'(blk_idx), 32'd0);
        chk({tag, "_w_out"},     w_out, 32'd0);
    endtask

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words [32];
        logic [MW-1:0] m;
        int p0, f0, idx0, pop_hold;

        rst = 1'b1; msg_valid = 1'b0; msg_in = '0;
`ifdef SCHED_FLUSH_EN
        flush = 1'b0;
`endif
        for (int i = 0; i < 128; i++) begin kv_en[i] = 1'b0; kv_w[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Known vectors: "abc" block in block 0, header-style padding in block 1
        for (int j = 0; j < 32; j++) words[j] = 32'd0;
        words[0] = 32'h61626380; words[15] = 32'h00000018;
        for (int j = 16; j < 20; j++) words[j] = $urandom();
        words[20] = 32'h80000000; words[31] = 32'h00000280;
        m = pack(words);
        kv_en[0] = 1; kv_w[0] = 32'h61626380;
        for (int t = 1; t < 15; t++) begin kv_en[t] = 1; kv_w[t] = 32'd0; end
        kv_en[15] = 1; kv_w[15] = 32'h00000018;
        kv_en[16] = 1; kv_w[16] = 32'h61626380;
        kv_en[17] = 1; kv_w[17] = 32'h000F0000;
        kv_en[64+4] = 1; kv_w[64+4] = 32'h80000000;
        for (int t = 5; t < 15; t++) begin kv_en[64+t] = 1; kv_w[64+t] = 32'd0; end
        kv_en[64+15] = 1; kv_w[64+15] = 32'h00000280;
        f0 = firsts;
        send_msg(m);
        wait_drain();
        chk("burst_cycles", 32'(last_pop_cyc - acc_cyc), 32'd128);
        chk("ready_after_last", 32'(msg_ready), 32'd1);
        chk("blk_first_count", 32'(firsts - f0), 32'd2);
        for (int i = 0; i < 128; i++) kv_en[i] = 1'b0;

        // Random back-pressure, with one long stall
        bp_mode = 1'b1;
        for (int r = 0; r < 3; r++) begin
            p0 = popped;
            send_msg(rand_msg());
            if (r == 1) begin
                wait_popped(p0 + 40);
                bp_mode = 1'b0; bp_const = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                idx0 = int'(w_idx); pop_hold = popped;
                repeat (30) @(posedge clk);
                #1;
                chk("stall_w_idx", 32'(w_idx), 32'(idx0));
                chk("stall_popped", 32'(popped), 32'(pop_hold));
                bp_const = 1'b1; bp_mode = 1'b1;
            end
            wait_drain();
        end
        bp_mode = 1'b0; bp_const = 1'b1;
        @(posedge clk); #1;

        // msg_valid held through RUN with other data: second message waits
        send_msg(rand_msg());
        p0 = accepts;
        msg_in = rand_msg();
        msg_valid = 1'b1;
        begin
            int n = 0;
            while (accepts == p0 && n < 500) begin @(posedge clk); #1; n++; end
            if (accepts == p0) chk("second_accept_timeout", 32'd1, 32'd0);
        end
        msg_valid = 1'b0;
        wait_drain();

        // Reset at block 1, w_idx 20
        p0 = popped;
        send_msg(rand_msg());
        wait_popped(p0 + 84);
        chk("pre_rst_w_idx", 32'(w_idx), 32'd20);
        chk("pre_rst_blk_idx", 32'(blk_idx), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        rst = 1'b0;
        check_idle("mid_rst");
        send_msg(rand_msg());
        wait_drain();

`ifdef SCHED_FLUSH_EN
        // Flush coincident with the handshake of word t=10
        p0 = popped;
        send_msg(rand_msg());
        wait_popped(p0 + 10);
        chk("pre_flush_w_idx", 32'(w_idx), 32'd10);
        flush = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        flush = 1'b0;
        check_idle("flush");
        send_msg(rand_msg());
        wait_drain();
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
